// File: rtl/alu_rs_pkg.sv
// Shared definitions for the ALU reservation station: opcodes, tag width, depth.
package alu_rs_pkg;
  localparam int TAG_W    = 3;
  localparam int RS_DEPTH = 4;
  localparam int NO_TAG   = 0;

  localparam logic [4:0] ADD  = 5'b00000;
  localparam logic [4:0] SUB  = 5'b00001;
  localparam logic [4:0] SLL  = 5'b00010;
  localparam logic [4:0] SLT  = 5'b00011;
  localparam logic [4:0] SLTU = 5'b00100;
  localparam logic [4:0] XOR  = 5'b00101;
  localparam logic [4:0] SRL  = 5'b00110;
  localparam logic [4:0] SRA  = 5'b00111;
  localparam logic [4:0] OR   = 5'b01000;
  localparam logic [4:0] AND  = 5'b01001;
  localparam logic [4:0] BEQ  = 5'b01010;
  localparam logic [4:0] BNE  = 5'b01011;
  localparam logic [4:0] BLT  = 5'b01100;
  localparam logic [4:0] BGE  = 5'b01101;
  localparam logic [4:0] BLTU = 5'b01110;
  localparam logic [4:0] BGEU = 5'b01111;
  localparam logic [4:0] JAL  = 5'b10000;
  localparam logic [4:0] JALR = 5'b10001;
  localparam logic [4:0] LT   = 5'b11010;
  localparam logic [4:0] LTU  = 5'b11011;
endpackage

// File: rtl/alu_rs_pick.sv
// Lowest-index set-bit finder; used for both free-slot and ready-entry selection.
module rs_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  output logic          found,
  output logic [IW-1:0] idx
);
  always_comb begin
    found = 1'b0;
    idx   = '0;
    // Descending scan so the lowest set bit is the last one to win.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        idx   = IW'(i);
      end
    end
  end
endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: holds dispatched ops until both operands are ready,
// snoops the CDB for wakeups and issues the lowest-index ready entry each cycle.
module alu_rs #(
  parameter int RS_DEPTH = 4,
  parameter int TAG_W    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             dispatch_valid,
  input  logic [4:0]       dispatch_op,
  input  logic [31:0]      dispatch_v1,
  input  logic [31:0]      dispatch_v2,
  input  logic [TAG_W-1:0] dispatch_q1,
  input  logic [TAG_W-1:0] dispatch_q2,
  input  logic [TAG_W-1:0] dispatch_des,
  input  logic             dispatch_is_branch,
  input  logic [TAG_W-1:0] cdb_des,
  input  logic [31:0]      cdb_result,
  output logic             rs_full,
  output logic [31:0]      alu_value_1,
  output logic [31:0]      alu_value_2,
  output logic [4:0]       alu_op,
  output logic [TAG_W-1:0] alu_des,
  output logic             alu_is_branch
);
  import alu_rs_pkg::*;

  localparam int IW = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;
  localparam logic [TAG_W-1:0] NONE = TAG_W'(NO_TAG);

  logic [RS_DEPTH-1:0] busy;
  logic [RS_DEPTH-1:0] ready;
  logic [RS_DEPTH-1:0] br;
  logic [4:0]          op  [RS_DEPTH];
  logic [31:0]         v1  [RS_DEPTH];
  logic [31:0]         v2  [RS_DEPTH];
  logic [TAG_W-1:0]    q1  [RS_DEPTH];
  logic [TAG_W-1:0]    q2  [RS_DEPTH];
  logic [TAG_W-1:0]    des [RS_DEPTH];

  logic          free_found, rdy_found, do_dispatch;
  logic [IW-1:0] free_idx, rdy_idx;

  always_comb begin
    ready = '0;
    for (int i = 0; i < RS_DEPTH; i++)
      ready[i] = busy[i] && (q1[i] == NONE) && (q2[i] == NONE);
  end

  rs_pick #(.N(RS_DEPTH), .IW(IW)) u_free_pick (.req(~busy), .found(free_found), .idx(free_idx));
  rs_pick #(.N(RS_DEPTH), .IW(IW)) u_rdy_pick  (.req(ready), .found(rdy_found),  .idx(rdy_idx));

  assign rs_full     = ~free_found;
  assign do_dispatch = dispatch_valid && free_found && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy          <= '0;
      alu_op        <= '0;
      alu_des       <= '0;
      alu_is_branch <= 1'b0;
      alu_value_1   <= '0;
      alu_value_2   <= '0;
    end else if (flush) begin
      busy          <= '0;
      alu_op        <= '0;
      alu_des       <= '0;
      alu_is_branch <= 1'b0;
    end else begin
      if (rdy_found) begin
        alu_op         <= op[rdy_idx];
        alu_des        <= des[rdy_idx];
        alu_is_branch  <= br[rdy_idx];
        alu_value_1    <= v1[rdy_idx];
        alu_value_2    <= v2[rdy_idx];
        busy[rdy_idx]  <= 1'b0;
      end else begin
        alu_op        <= '0;
        alu_des       <= '0;
        alu_is_branch <= 1'b0;
      end
      // The free slot is never the issuing slot, so both updates can coexist.
      if (do_dispatch)
        busy[free_idx] <= 1'b1;
    end
  end

  // Entry payload needs no reset: busy gates every use of it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (cdb_des != NONE && busy[i] && q1[i] == cdb_des) begin
        v1[i] <= cdb_result;
        q1[i] <= NONE;
      end
      if (cdb_des != NONE && busy[i] && q2[i] == cdb_des) begin
        v2[i] <= cdb_result;
        q2[i] <= NONE;
      end
      if (do_dispatch && free_idx == IW'(i)) begin
        op[i]  <= dispatch_op;
        des[i] <= dispatch_des;
        br[i]  <= dispatch_is_branch;
        if (dispatch_q1 != NONE && dispatch_q1 == cdb_des) begin
          v1[i] <= cdb_result;
          q1[i] <= NONE;
        end else begin
          v1[i] <= dispatch_v1;
          q1[i] <= dispatch_q1;
        end
        if (dispatch_q2 != NONE && dispatch_q2 == cdb_des) begin
          v2[i] <= cdb_result;
          q2[i] <= NONE;
        end else begin
          v2[i] <= dispatch_v2;
          q2[i] <= dispatch_q2;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_rs.sv
// Self-checking bench for alu_rs: directed scenarios plus randomized traffic
// compared against an entry-list reference model.
module tb_alu_rs;
  import alu_rs_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        dispatch_valid;
  logic [4:0]  dispatch_op;
  logic [31:0] dispatch_v1, dispatch_v2;
  logic [2:0]  dispatch_q1, dispatch_q2, dispatch_des;
  logic        dispatch_is_branch;
  logic [2:0]  cdb_des;
  logic [31:0] cdb_result;
  logic        rs_full;
  logic [31:0] alu_value_1, alu_value_2;
  logic [4:0]  alu_op;
  logic [2:0]  alu_des;
  logic        alu_is_branch;

  int n_cmp = 0;
  int n_err = 0;

  // reference model: four slots, each a pending instruction or empty
  bit          m_busy [4];
  logic [4:0]  m_op   [4];
  logic [31:0] m_v1   [4];
  logic [31:0] m_v2   [4];
  int          m_q1   [4];
  int          m_q2   [4];
  int          m_des  [4];
  bit          m_br   [4];
  logic [4:0]  e_op;
  logic [31:0] e_v1, e_v2;
  int          e_des;
  bit          e_br;

  alu_rs dut (
    .clk(clk), .rst(rst), .flush(flush),
    .dispatch_valid(dispatch_valid), .dispatch_op(dispatch_op),
    .dispatch_v1(dispatch_v1), .dispatch_v2(dispatch_v2),
    .dispatch_q1(dispatch_q1), .dispatch_q2(dispatch_q2),
    .dispatch_des(dispatch_des), .dispatch_is_branch(dispatch_is_branch),
    .cdb_des(cdb_des), .cdb_result(cdb_result),
    .rs_full(rs_full), .alu_value_1(alu_value_1), .alu_value_2(alu_value_2),
    .alu_op(alu_op), .alu_des(alu_des), .alu_is_branch(alu_is_branch)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) m_busy[i] = 0;
    e_op = '0; e_des = 0; e_br = 0; e_v1 = '0; e_v2 = '0;
  endtask

  function automatic int model_count();
    int n = 0;
    for (int i = 0; i < 4; i++) if (m_busy[i]) n++;
    return n;
  endfunction

  task automatic model_step();
    int iss, slot, cnt;
    cnt = model_count();
    if (flush) begin
      for (int i = 0; i < 4; i++) m_busy[i] = 0;
      e_op = '0; e_des = 0; e_br = 0;
      return;
    end
    iss = -1;
    for (int i = 0; i < 4; i++)
      if (iss < 0 && m_busy[i] && m_q1[i] == 0 && m_q2[i] == 0) iss = i;
    slot = -1;
    if (dispatch_valid && cnt < 4)
      for (int i = 0; i < 4; i++) if (slot < 0 && !m_busy[i]) slot = i;
    if (iss >= 0) begin
      e_op = m_op[iss]; e_v1 = m_v1[iss]; e_v2 = m_v2[iss];
      e_des = m_des[iss]; e_br = m_br[iss];
      m_busy[iss] = 0;
    end else begin
      e_op = '0; e_des = 0; e_br = 0;
    end
    if (cdb_des != 0)
      for (int i = 0; i < 4; i++) if (m_busy[i]) begin
        if (m_q1[i] == int'(cdb_des)) begin m_q1[i] = 0; m_v1[i] = cdb_result; end
        if (m_q2[i] == int'(cdb_des)) begin m_q2[i] = 0; m_v2[i] = cdb_result; end
      end
    if (slot >= 0) begin
      m_busy[slot] = 1; m_op[slot] = dispatch_op; m_des[slot] = int'(dispatch_des);
      m_br[slot] = dispatch_is_branch;
      m_q1[slot] = int'(dispatch_q1); m_v1[slot] = dispatch_v1;
      m_q2[slot] = int'(dispatch_q2); m_v2[slot] = dispatch_v2;
      if (m_q1[slot] != 0 && dispatch_q1 == cdb_des) begin m_q1[slot] = 0; m_v1[slot] = cdb_result; end
      if (m_q2[slot] != 0 && dispatch_q2 == cdb_des) begin m_q2[slot] = 0; m_v2[slot] = cdb_result; end
    end
  endtask

  task automatic idle();
    flush = 0; dispatch_valid = 0; cdb_des = '0; cdb_result = '0;
    dispatch_op = '0; dispatch_v1 = '0; dispatch_v2 = '0;
    dispatch_q1 = '0; dispatch_q2 = '0; dispatch_des = '0; dispatch_is_branch = 0;
  endtask

  task automatic disp(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                      input int qa, input int qb, input int d, input bit isb);
    dispatch_valid = 1; dispatch_op = o; dispatch_v1 = a; dispatch_v2 = b;
    dispatch_q1 = 3'(qa); dispatch_q2 = 3'(qb); dispatch_des = 3'(d); dispatch_is_branch = isb;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("alu_op", 32'(alu_op), 32'(e_op));
    chk("alu_des", 32'(alu_des), 32'(e_des));
    chk("alu_is_branch", 32'(alu_is_branch), 32'(e_br));
    chk("alu_value_1", alu_value_1, e_v1);
    chk("alu_value_2", alu_value_2, e_v2);
    chk("rs_full", 32'(rs_full), 32'(model_count() == 4));
    idle();
  endtask

  initial begin
    idle();
    rst = 1;
    model_clear();
    #2;
    chk("reset_op", 32'(alu_op), 32'd0);
    chk("reset_full", 32'(rs_full), 32'd0);
    chk("reset_v1", alu_value_1, 32'd0);
    @(posedge clk);
    #7 rst = 0;

    // single ready ADD: one-cycle latency, then idle
    disp(ADD, 32'd5, 32'd7, 0, 0, 4, 0);
    tick();
    tick();
    chk("add_v1", alu_value_1, 32'd5);
    chk("add_v2", alu_value_2, 32'd7);
    chk("add_des", 32'(alu_des), 32'd4);
    tick();
    chk("add_after_op", 32'(alu_op), 32'd0);
    chk("add_after_des", 32'(alu_des), 32'd0);

    // wakeup two cycles after dispatch
    disp(SUB, 32'd1, 32'd2, 3, 0, 5, 0);
    tick();
    tick();
    cdb_des = 3'd3; cdb_result = 32'h10;
    tick();
    chk("wake_wait_op", 32'(alu_op), 32'd0);
    tick();
    chk("wake_op", 32'(alu_op), 32'(SUB));
    chk("wake_v1", alu_value_1, 32'h10);

    // dispatch bypass from a same-cycle broadcast
    disp(XOR, 32'd3, 32'd4, 0, 5, 6, 1);
    cdb_des = 3'd5; cdb_result = 32'd9;
    tick();
    tick();
    chk("bypass_v2", alu_value_2, 32'd9);
    chk("bypass_br", 32'(alu_is_branch), 32'd1);

    // fill, overflow, then drain in index order
    for (int i = 0; i < 4; i++) begin
      disp(OR, 32'(i), 32'd0, 2, 0, i + 1, 0);
      tick();
    end
    chk("fill_full", 32'(rs_full), 32'd1);
    disp(AND, 32'd77, 32'd0, 0, 0, 7, 0);
    tick();
    chk("drop_full", 32'(rs_full), 32'd1);
    cdb_des = 3'd2; cdb_result = 32'hAB;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("drain_des", 32'(alu_des), 32'(i + 1));
    end
    tick();
    chk("drain_idle", 32'(alu_op), 32'd0);

    // flush with two waiting entries
    disp(SLT, 32'd1, 32'd1, 6, 0, 1, 0);
    tick();
    disp(SLT, 32'd2, 32'd2, 0, 6, 2, 0);
    tick();
    flush = 1;
    tick();
    chk("flush_full", 32'(rs_full), 32'd0);
    cdb_des = 3'd6; cdb_result = 32'd1;
    tick();
    tick();
    chk("flush_noissue", 32'(alu_op), 32'd0);

    // async reset mid-cycle with a ready entry pending
    disp(SRA, 32'd11, 32'd12, 0, 0, 3, 1);
    tick();
    disp(JALR, 32'd13, 32'd14, 0, 0, 4, 1);
    tick();
    #3 rst = 1;
    #1;
    chk("arst_op", 32'(alu_op), 32'd0);
    chk("arst_v1", alu_value_1, 32'd0);
    chk("arst_br", 32'(alu_is_branch), 32'd0);
    chk("arst_full", 32'(rs_full), 32'd0);
    model_clear();
    @(posedge clk);
    #2 rst = 0;
    tick();
    chk("arst_noissue", 32'(alu_op), 32'd0);
    disp(LTU, 32'd21, 32'd22, 0, 0, 7, 0);
    tick();
    tick();
    chk("post_rst_op", 32'(alu_op), 32'(LTU));

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 1) == 1)
        disp(5'($urandom_range(0, 31)), $urandom, $urandom,
             ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(1, 7)),
             ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(1, 7)),
             int'($urandom_range(1, 7)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 9) < 4) begin
        cdb_des = 3'($urandom_range(1, 7));
        cdb_result = $urandom;
      end
      flush = ($urandom_range(0, 39) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
